// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg
// Shared types and constants for the multiplier operand sequencer.
// Holds the sequencer state encoding, the operand/product widths, the
// default FIFO geometry and a small helper used by the optional
// zero-operand bypass (MULT_SEQ_ZERO_BYPASS_EN in the top module).
// No ports: this file only provides declarations.

package mult_seq_pkg;

    localparam int OPW           = 8;
    localparam int PRW           = 16;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_AW    = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } seqState_t;

    // True when the product is trivially zero and the multiplier can be skipped.
    function automatic logic hasZeroOperand(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        return (a == '0) || (b == '0);
    endfunction

endpackage

// File: rtl/mult_seq_fifo.sv
// mult_seq_fifo
// Small synchronous FIFO buffering operand pairs in front of the multiplier.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset (empties the FIFO)
//   push_i   in   write request; ignored while full
//   wdata_i  in   W-bit entry to write
//   pop_i    in   read request; ignored while empty
//   rdata_o  out  head entry (valid while not empty)
//   full_o   out  all DEPTH entries occupied
//   empty_o  out  no entries occupied
//   count_o  out  occupied entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.

module mult_seq_fifo
    import mult_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW,
    parameter int W     = 2 * OPW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          doPush;
    logic          doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    // Requests are qualified here so a stray push when full or pop when
    // empty can never corrupt the pointers or the count.
    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    // Storage carries no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers wrap modulo DEPTH by overflow; a simultaneous push and pop
    // leaves the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

endmodule

// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer
// Front end and result capture for the repeated-addition 8x8 multiplier.
// Operand pairs arrive on a valid/ready stream and are queued in a FIFO.
// One pair at a time is issued with a single-cycle start pulse; the block
// then waits for the multiplier to go busy and idle again, captures the
// 16-bit product and offers it on a valid/ready output stream.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   in_valid/in_ready     operand stream handshake (in_ready = FIFO not full)
//   in_a, in_b            8-bit unsigned operands
//   out_valid/out_ready   product stream handshake
//   out_r                 16-bit product, held while out_valid && !out_ready
//   mul_start             one-cycle start pulse to the multiplier
//   mul_a, mul_b          operands to the multiplier, stable until capture
//   mul_ready, mul_r      multiplier idle flag and product
//   fifo_count            occupied FIFO entries
// Build option: define MULT_SEQ_ZERO_BYPASS_EN to answer pairs with a zero
// operand directly (result 0) without involving the multiplier.

module mult_operand_sequencer
    import mult_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_a,
    input  logic [OPW-1:0]  in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PRW-1:0]  out_r,
    output logic            mul_start,
    output logic [OPW-1:0]  mul_a,
    output logic [OPW-1:0]  mul_b,
    input  logic            mul_ready,
    input  logic [PRW-1:0]  mul_r,
    output logic [AW:0]     fifo_count
);

    seqState_t         state_q;
    seqState_t         state_d;
    logic [OPW-1:0]    opA_q;
    logic [OPW-1:0]    opA_d;
    logic [OPW-1:0]    opB_q;
    logic [OPW-1:0]    opB_d;
    logic [PRW-1:0]    outR_q;
    logic [PRW-1:0]    outR_d;
    logic              outValid_q;
    logic              outValid_d;

    logic              fifoPush;
    logic              fifoPop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [2*OPW-1:0]  fifoRdata;
    logic [OPW-1:0]    headA;
    logic [OPW-1:0]    headB;

    assign in_ready  = !fifoFull;
    assign fifoPush  = in_valid && !fifoFull;
    assign headA     = fifoRdata[2*OPW-1:OPW];
    assign headB     = fifoRdata[OPW-1:0];

    assign out_valid = outValid_q;
    assign out_r     = outR_q;
    assign mul_a     = opA_q;
    assign mul_b     = opB_q;

    mult_seq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (2*OPW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifoPush),
        .wdata_i ({in_a, in_b}),
        .pop_i   (fifoPop),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifo_count)
    );

    // State, operand and result registers. Reset discards any in-flight
    // product along with the queued pairs held by the FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            outR_q     <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            outR_q     <= outR_d;
            outValid_q <= outValid_d;
        end
    end

    // Sequencing: pop a pair only when the multiplier is idle, pulse start
    // once, wait for the busy edge and then the idle edge, capture the
    // product and hold it until the consumer takes it. Only one
    // multiplication is ever in flight, so results leave in input order.
    // The operand registers are only loaded in IDLE, which keeps mul_a and
    // mul_b stable for the multiplier's second operand sample.
    always_comb begin
        state_d    = state_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        outR_d     = outR_q;
        outValid_d = outValid_q;
        fifoPop    = 1'b0;
        mul_start  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty && mul_ready) begin
                    fifoPop = 1'b1;
                    opA_d   = headA;
                    opB_d   = headB;
`ifdef MULT_SEQ_ZERO_BYPASS_EN
                    if (hasZeroOperand(headA, headB)) begin
                        outR_d     = '0;
                        outValid_d = 1'b1;
                        state_d    = ST_HOLD;
                    end else begin
                        state_d = ST_ISSUE;
                    end
`else
                    state_d = ST_ISSUE;
`endif
                end
            end

            ST_ISSUE: begin
                mul_start = 1'b1;
                state_d   = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (!mul_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (mul_ready) begin
                    outR_d     = mul_r;
                    outValid_d = 1'b1;
                    state_d    = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (outValid_q && out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// tb_mult_operand_sequencer
// Directed bench for mult_operand_sequencer. A behavioural model of the
// repeated-addition multiplier sits on the mul_* side: busy for b+1
// cycles (one cycle when either operand is zero) and it forms the product
// from mul_a/mul_b at its final busy edge, so operands that move early
// give a wrong product.

module tb_mult_operand_sequencer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

`ifdef MULT_SEQ_ZERO_BYPASS_EN
    localparam int ZERO_LAT    = 2;
    localparam int ZERO_STARTS = 0;
    localparam int ZERO_GAP    = 2;
`else
    localparam int ZERO_LAT    = 5;
    localparam int ZERO_STARTS = 1;
    localparam int ZERO_GAP    = 5;
`endif

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_a;
    logic [7:0]    in_b;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_r;
    logic          mul_start;
    logic [7:0]    mul_a;
    logic [7:0]    mul_b;
    logic          mul_ready;
    logic [15:0]   mul_r;
    logic [AW:0]   fifo_count;

    int compared;
    int mismatched;
    int startPulses;
    int startViolations;

    logic        mReady;
    logic [15:0] mR;
    logic [8:0]  mCnt;

    mult_operand_sequencer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_ready  (mul_ready),
        .mul_r      (mul_r),
        .fifo_count (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mul_ready = mReady;
    assign mul_r     = mR;

    // Multiplier model: idle until a start pulse, then busy b+1 cycles
    // (or one cycle on the zero path), product computed at the last edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mReady <= 1'b1;
            mR     <= '0;
            mCnt   <= '0;
        end else if (mReady) begin
            if (mul_start) begin
                mReady <= 1'b0;
                mCnt   <= (mul_a == 8'd0 || mul_b == 8'd0) ? 9'd1 : (9'(mul_b) + 9'd1);
            end
        end else begin
            if (mCnt == 9'd1) begin
                mReady <= 1'b1;
                mR     <= 16'(mul_a) * 16'(mul_b);
            end
            mCnt <= mCnt - 9'd1;
        end
    end

    // Start pulses are counted away from the clock edge.
    always @(negedge clock) begin
        if (mul_start) startPulses++;
        if (mul_start && !mReady) startViolations++;
    end

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        compared++;
        if (out_r !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_out_r: got %0d expected 0", out_r); end
        compared++;
        if (mul_start !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mul_start: got %b expected 0", mul_start); end
        compared++;
        if (mul_a !== 8'd0 || mul_b !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_mul_ops: got a=%0d b=%0d expected 0 0", mul_a, mul_b); end
        compared++;
        if (fifo_count !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    endtask

    // Single pairs from idle: latency counted in falling edges after the
    // input handshake edge E0, which equals the cycle number E0+n.
    task automatic test_single;
        int va[3];
        int vb[3];
        int vLat[3];
        int vProd[3];
        int vStarts[3];
        int n;
        logic seen;
        va = '{3, 0, 6};
        vb = '{5, 7, 1};
        vLat = '{10, ZERO_LAT, 6};
        vProd = '{15, 0, 6};
        vStarts = '{1, ZERO_STARTS, 1};
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            startPulses = 0;
            @(negedge clock);
            in_valid = 1'b1;
            in_a = 8'(va[v]);
            in_b = 8'(vb[v]);
            compared++;
            if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL single_in_ready[%0d]: got %b expected 1", v, in_ready); end
            @(posedge clock);
            n = 0;
            seen = 1'b0;
            while (n < 100 && !seen) begin
                @(negedge clock);
                n++;
                in_valid = 1'b0;
                if (out_valid) seen = 1'b1;
            end
            compared++;
            if (!seen || n != vLat[v]) begin mismatched++; $display("[TB] FAIL single_latency[%0d]: got %0d (seen=%b) expected %0d", v, n, seen, vLat[v]); end
            compared++;
            if (out_r !== 16'(vProd[v])) begin mismatched++; $display("[TB] FAIL single_product[%0d]: got %0d expected %0d", v, out_r, vProd[v]); end
            @(negedge clock);
            compared++;
            if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_accept[%0d]: out_valid got %b expected 0", v, out_valid); end
            compared++;
            if (startPulses != vStarts[v]) begin mismatched++; $display("[TB] FAIL single_start_pulses[%0d]: got %0d expected %0d", v, startPulses, vStarts[v]); end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int k;
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b1;
        in_a = 8'd255;
        in_b = 8'd255;
        @(negedge clock);
        in_a = 8'd2;
        in_b = 8'd0;
        @(negedge clock);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clock);
            n++;
        end
        compared++;
        if (!out_valid || out_r !== 16'd65025) begin mismatched++; $display("[TB] FAIL b2b_first: got valid=%b r=%0d expected valid=1 r=65025", out_valid, out_r); end
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!out_valid && k < 50);
        compared++;
        if (k != ZERO_GAP) begin mismatched++; $display("[TB] FAIL b2b_gap: got %0d cycles expected %0d", k, ZERO_GAP); end
        compared++;
        if (!out_valid || out_r !== 16'd0) begin mismatched++; $display("[TB] FAIL b2b_second: got valid=%b r=%0d expected valid=1 r=0", out_valid, out_r); end
        @(negedge clock);
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_drained: out_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_fill;
        int fa[6];
        int fb[6];
        int fp[5];
        int i;
        int j;
        int c;
        int idx;
        logic blocked;
        fa = '{10, 7, 0, 15, 100, 9};
        fb = '{3, 7, 9, 2, 4, 9};
        fp = '{30, 49, 0, 30, 400};
        out_ready = 1'b0;
        i = 0;
        blocked = 1'b0;
        for (int cc = 0; cc < 12 && !blocked && i < 6; cc++) begin
            @(negedge clock);
            idx = (i < 5) ? i : 5;
            in_valid = 1'b1;
            in_a = 8'(fa[idx]);
            in_b = 8'(fb[idx]);
            if (in_ready) i++;
            else blocked = 1'b1;
        end
        // One pair goes straight to the multiplier, so DEPTH+1 are accepted.
        compared++;
        if (!blocked || i != DEPTH + 1) begin mismatched++; $display("[TB] FAIL fill_accepted: got %0d (blocked=%b) expected %0d", i, blocked, DEPTH + 1); end
        compared++;
        if (fifo_count !== 3'(DEPTH)) begin mismatched++; $display("[TB] FAIL fill_count: got %0d expected %0d", fifo_count, DEPTH); end
        repeat (4) @(negedge clock);
        compared++;
        if (fifo_count !== 3'(DEPTH) || in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_ignored: got count=%0d in_ready=%b expected %0d 0", fifo_count, in_ready, DEPTH); end
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 100) begin
            @(negedge clock);
            c++;
        end
        compared++;
        if (!out_valid || out_r !== 16'd30) begin mismatched++; $display("[TB] FAIL fill_first: got valid=%b r=%0d expected valid=1 r=30", out_valid, out_r); end
        repeat (5) @(negedge clock);
        compared++;
        if (out_valid !== 1'b1 || out_r !== 16'd30) begin mismatched++; $display("[TB] FAIL fill_hold: got valid=%b r=%0d expected valid=1 r=30", out_valid, out_r); end
        out_ready = 1'b1;
        j = 0;
        c = 0;
        while (j < 5 && c < 1000) begin
            if (out_valid) begin
                compared++;
                if (out_r !== 16'(fp[j])) begin mismatched++; $display("[TB] FAIL fill_drain[%0d]: got %0d expected %0d", j, out_r, fp[j]); end
                j++;
            end
            @(negedge clock);
            c++;
        end
        compared++;
        if (j != 5) begin mismatched++; $display("[TB] FAIL fill_drain_count: got %0d expected 5", j); end
        compared++;
        if (fifo_count !== 3'd0) begin mismatched++; $display("[TB] FAIL fill_empty: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_reset_mid;
        logic seenOut;
        logic seenStart;
        out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        in_a = 8'd200;
        in_b = 8'd100;
        @(negedge clock);
        in_a = 8'd1;
        in_b = 8'd1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        compared++;
        if (fifo_count !== 3'd1 || out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_before: got count=%0d valid=%b expected 1 0", fifo_count, out_valid); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_after: got valid=%b count=%0d in_ready=%b expected 0 0 1", out_valid, fifo_count, in_ready); end
        out_ready = 1'b1;
        seenOut = 1'b0;
        seenStart = 1'b0;
        repeat (200) begin
            @(negedge clock);
            if (out_valid) seenOut = 1'b1;
            if (mul_start) seenStart = 1'b1;
        end
        compared++;
        if (seenOut !== 1'b0 || seenStart !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_quiet: got out=%b start=%b expected 0 0", seenOut, seenStart); end
    endtask

    // Random pairs with random backpressure; expected products queued on
    // each accepted input and compared on each accepted output.
    task automatic test_random;
        logic [15:0] expQ[$];
        logic [15:0] expVal;
        logic [7:0] pa;
        logic [7:0] pb;
        logic pending;
        int sent;
        int received;
        int cyc;
        sent = 0;
        received = 0;
        cyc = 0;
        pending = 1'b0;
        pa = 8'd0;
        pb = 8'd0;
        startViolations = 0;
        while (received < 200 && cyc < 60000) begin
            @(negedge clock);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL random_unexpected: got %0d expected no output", out_r);
                end else begin
                    expVal = expQ.pop_front();
                    if (out_r !== expVal) begin mismatched++; $display("[TB] FAIL random_product[%0d]: got %0d expected %0d", received, out_r, expVal); end
                end
                received++;
            end
            if (sent < 200) begin
                if (!pending) begin
                    pa = 8'($urandom_range(0, 255));
                    pb = 8'($urandom_range(0, 31));
                    if ($urandom_range(0, 7) == 0) pa = 8'd0;
                    pending = ($urandom_range(0, 2) != 0);
                end
                in_valid = pending;
                in_a = pa;
                in_b = pb;
                if (pending && in_ready) begin
                    expQ.push_back(16'(pa) * 16'(pb));
                    sent++;
                    pending = 1'b0;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        compared++;
        if (received != 200) begin mismatched++; $display("[TB] FAIL random_received: got %0d expected 200", received); end
        compared++;
        if (expQ.size() != 0) begin mismatched++; $display("[TB] FAIL random_leftover: got %0d expected 0", expQ.size()); end
        compared++;
        if (startViolations != 0) begin mismatched++; $display("[TB] FAIL random_start_while_busy: got %0d expected 0", startViolations); end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        startPulses = 0;
        startViolations = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_a = 8'd0;
        in_b = 8'd0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_operand_sequencer.md
# mult_operand_sequencer

Front-end and result-capture stage for the repeated-addition 8x8 multiplier. Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. Issues each pair to the multiplier with a one-cycle start pulse and waits out its variable-length busy period. Captures the 16-bit product and presents it on a valid/ready output stream, so upstream logic never has to track multiplier timing.

## Interface
Parameters:
- DEPTH, 4: operand FIFO entries; power of two, at least 2.
- AW, 2: FIFO pointer width, log2(DEPTH).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals not-full.
- in_a  in  8  multiplicand.
- in_b  in  8  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_r  out  16  product.
- mul_start  out  1  start pulse to the multiplier.
- mul_a  out  8  operand A to the multiplier.
- mul_b  out  8  operand B to the multiplier.
- mul_ready  in  1  multiplier idle flag.
- mul_r  in  16  multiplier product.
- fifo_count  out  AW+1  occupied FIFO entries.

The multiplier's active-low reset is driven by ~reset at the parent level, so both blocks reset together.

## Operation
- FIFO:
  - Push on in_valid && in_ready.
  - Pop only when the FSM leaves IDLE.
  - Push while full is impossible because in_ready is 0.
  - Simultaneous push and pop on a non-full FIFO leaves fifo_count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
  - IDLE: if the FIFO is non-empty and mul_ready=1, pop the head into op_a/op_b, then go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for mul_ready=0, then go to WAIT_DONE. This state is always exactly one cycle with a correct multiplier.
  - WAIT_DONE: wait for mul_ready=1. On that edge, register mul_r into out_r, set out_valid=1, and go to HOLD.
  - HOLD: on out_valid && out_ready, clear out_valid and go to IDLE. The next pop happens in IDLE one cycle later.
- mul_a and mul_b come from op_a and op_b. They stay stable from ISSUE through WAIT_DONE because the multiplier samples operands both at start and one cycle later.
- mul_start is 0 in every state except ISSUE.
- Products are unsigned: out_r = in_a * in_b, full 16 bits, no truncation.
- Results leave in input order, with only one multiplication in flight.
- Reset mid-operation: the FIFO empties, the FSM returns to IDLE, and any in-flight product is discarded.

## Timing
- Reset values:
  - in_ready=1.
  - out_valid=0, out_r=0.
  - mul_start=0, mul_a=0, mul_b=0.
  - fifo_count=0.
- Latency, measured from the input handshake edge E0 with an empty FIFO, idle FSM and idle multiplier:
  - in_b≠0 and in_a≠0: out_valid rises in cycle E0+in_b+5, since the multiplier is busy for in_b+1 cycles.
  - Either operand zero: out_valid rises in cycle E0+5, since the multiplier takes its one-cycle zero path.
- Throughput: one product per (busy+4) cycles while out_ready is held high.
- out_valid and out_r are held unchanged while out_ready=0.

## Configuration
- MULT_SEQ_ZERO_BYPASS_EN defined:
  - In IDLE, a popped pair with in_a==0 or in_b==0 skips the multiplier entirely.
  - out_r=0 and out_valid=1 on the pop edge, then the FSM goes to HOLD.
  - Zero-operand latency becomes E0+2, and no mul_start is issued.
- Undefined: every pair goes through the multiplier as described under Operation.

## Structure
- Package mult_seq_pkg holds:
  - the state enum (3-bit encoding);
  - the operand width constant 8 and product width constant 16;
  - the default DEPTH.
- Sub-module mult_seq_fifo is a synchronous FIFO with async active-high reset, a count output, and push/pop/full/empty signals. It is instantiated once.
- The FSM, operand registers and result register live in the top module.

## Test plan
- Reset while WAIT_DONE with a=200, b=100 -> out_valid=0 and fifo_count=0 on the next cycle; no output appears afterwards.
- Single pair a=3, b=5 with out_ready=1 -> one mul_start pulse; out_valid in E0+10 with out_r=15.
- Push a=255, b=255 then a=2, b=0 back to back -> outputs 65025 then 0, in order. The second output is at most 5 cycles after the first is accepted, or 2 cycles with MULT_SEQ_ZERO_BYPASS_EN.
- Fill with DEPTH pairs while out_ready=0 -> in_ready=0 at fifo_count=DEPTH; a further in_valid is ignored and out_r stays held. Releasing out_ready drains all pairs with correct products.
- Random 200 pairs with random out_ready backpressure -> every product matches a*b, order is preserved, and mul_start never fires while mul_ready=0.
